// File: rtl/conv_psum_post_if.sv
// Partial-sum post-processor bus: MAC beats and tile config in, requantized results out.
// Ports (master drives): vld_i, acc_i (4 lanes of ACC_W), clr_i, cfg_num_ch, cfg_bias,
//   cfg_shift, cfg_relu, cfg_pool.
// Ports (slave drives): busy_o, vld_o, data_o.
interface conv_psum_post_if #(
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned BIAS_W = 16
);
  logic                  vld_i;
  logic [4*ACC_W-1:0]    acc_i;
  logic                  clr_i;
  logic [7:0]            cfg_num_ch;
  logic [BIAS_W-1:0]     cfg_bias;
  logic [4:0]            cfg_shift;
  logic                  cfg_relu;
  logic                  cfg_pool;
  logic                  busy_o;
  logic                  vld_o;
  logic [31:0]           data_o;

  modport master (
    output vld_i, acc_i, clr_i, cfg_num_ch, cfg_bias, cfg_shift, cfg_relu, cfg_pool,
    input  busy_o, vld_o, data_o
  );

  modport slave (
    input  vld_i, acc_i, clr_i, cfg_num_ch, cfg_bias, cfg_shift, cfg_relu, cfg_pool,
    output busy_o, vld_o, data_o
  );
endinterface

// File: rtl/conv_psum_post.sv
// Post-MAC tile pipeline: accumulates 2x2 partial sums over channel passes, adds bias,
// optional ReLU, round/shift/saturate to int8, optional 2x2 max-pool.
// Ports: clk, rstn (synchronous active-low), bus (conv_psum_post_if.slave).
// Latency: last beat sampled at edge T -> vld_o high after edge T+3.
module conv_psum_post #(
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned PSUM_W = 28,
  parameter int unsigned BIAS_W = 16
) (
  input logic             clk,
  input logic             rstn,
  conv_psum_post_if.slave bus
);
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned MAX_SH = 20;
  localparam logic signed [PSUM_W:0] Q_MAX = (PSUM_W+1)'(127);
  localparam logic signed [PSUM_W:0] Q_MIN = (PSUM_W+1)'(-128);

  // stage A: beat counter, accumulators, tile config latch
  logic [CNT_W-1:0]         cnt, n_lat, n_eff, cnt_base;
  logic                     first, last;
  logic signed [ACC_W-1:0]  lane [LANES];
  logic signed [PSUM_W-1:0] psum [LANES];
  logic                     a_vld;
  logic signed [BIAS_W-1:0] bias_lat;
  logic [SH_W-1:0]          sh_lat;
  logic                     relu_lat, pool_lat;

  // stage B: biased sums
  logic                     b_vld;
  logic signed [PSUM_W-1:0] s [LANES];
  logic [SH_W-1:0]          b_sh;
  logic                     b_relu, b_pool;

  // stage C: int8 lanes
  logic                     c_vld;
  logic signed [7:0]        q [LANES];
  logic signed [7:0]        q_nxt [LANES];
  logic                     c_pool;
  logic [31:0]              d_nxt;

  // ReLU, round-half-up arithmetic shift, saturate to int8
  function automatic logic signed [7:0] requant(input logic signed [PSUM_W-1:0] v,
                                                input logic [SH_W-1:0] sh,
                                                input logic relu);
    logic signed [PSUM_W:0] r, rnd, t;
    if (relu && v < 0) r = '0;
    else               r = (PSUM_W+1)'(v);
    rnd = '0;
    if (sh != '0) rnd[sh - SH_W'(1)] = 1'b1;
    t = (r + rnd) >>> sh;
    if (t > Q_MAX)      return 8'sh7f;
    else if (t < Q_MIN) return 8'sh80;
    else                return t[7:0];
  endfunction

  function automatic logic signed [7:0] max4(input logic signed [7:0] a, b, c, d);
    logic signed [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // A clear forces this beat to open a new tile; N=0 behaves as N=1
  always_comb begin
    first    = (cnt == '0) || bus.clr_i;
    cnt_base = first ? '0 : cnt;
    n_eff    = first ? bus.cfg_num_ch : n_lat;
    if (n_eff == '0) n_eff = CNT_W'(1);
    last     = (cnt_base == n_eff - CNT_W'(1));
    for (int k = 0; k < LANES; k++) lane[k] = bus.acc_i[k*ACC_W +: ACC_W];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= '0;
      n_lat    <= '0;
      bias_lat <= '0;
      sh_lat   <= '0;
      relu_lat <= 1'b0;
      pool_lat <= 1'b0;
      a_vld    <= 1'b0;
      for (int k = 0; k < LANES; k++) psum[k] <= '0;
    end else begin
      a_vld <= 1'b0;
      if (bus.vld_i) begin
        if (first) begin
          n_lat    <= n_eff;
          bias_lat <= bus.cfg_bias;
          sh_lat   <= (bus.cfg_shift > SH_W'(MAX_SH)) ? SH_W'(MAX_SH) : bus.cfg_shift;
          relu_lat <= bus.cfg_relu;
          pool_lat <= bus.cfg_pool;
        end
        for (int k = 0; k < LANES; k++)
          psum[k] <= first ? PSUM_W'(lane[k]) : psum[k] + PSUM_W'(lane[k]);
        if (last) begin
          cnt   <= '0;
          a_vld <= 1'b1;
        end else begin
          cnt <= cnt_base + CNT_W'(1);
        end
      end else if (bus.clr_i) begin
        cnt <= '0;
      end
    end
  end

  assign bus.busy_o = (cnt != '0);

  // stage B: bias add, config rides along with the tile
  always_ff @(posedge clk) begin
    if (!rstn) begin
      b_vld  <= 1'b0;
      b_sh   <= '0;
      b_relu <= 1'b0;
      b_pool <= 1'b0;
      for (int k = 0; k < LANES; k++) s[k] <= '0;
    end else begin
      b_vld <= a_vld;
      if (a_vld) begin
        b_sh   <= sh_lat;
        b_relu <= relu_lat;
        b_pool <= pool_lat;
        for (int k = 0; k < LANES; k++) s[k] <= psum[k] + PSUM_W'(bias_lat);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) q_nxt[k] = requant(s[k], b_sh, b_relu);
  end

  // stage C: requantize
  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_vld  <= 1'b0;
      c_pool <= 1'b0;
      for (int k = 0; k < LANES; k++) q[k] <= '0;
    end else begin
      c_vld <= b_vld;
      if (b_vld) begin
        c_pool <= b_pool;
        for (int k = 0; k < LANES; k++) q[k] <= q_nxt[k];
      end
    end
  end

  always_comb begin
    if (c_pool) d_nxt = {24'd0, max4(q[0], q[1], q[2], q[3])};
    else        d_nxt = {q[3], q[2], q[1], q[0]};
  end

  // stage D: output register, data holds between pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.vld_o  <= 1'b0;
      bus.data_o <= '0;
    end else begin
      bus.vld_o <= c_vld;
      if (c_vld) bus.data_o <= d_nxt;
    end
  end
endmodule
